// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle between the timekeeping logic (master) and the scan controller (slave).
// The master owns the digit/dp/blink inputs and the load request level.
// The slave owns the segment pins and the frame/load pulses.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 5
);
  logic [4*NUM_DIGITS-1:0] digit_bcd;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    load_req;
  logic                    load_ack;
  logic [7:0]              SEG_DATA;
  logic [NUM_DIGITS-1:0]   SEG_SEL;
  logic                    frame_tick;

  modport master (
    output digit_bcd, dp_mask, blink_mask, load_req,
    input  load_ack, SEG_DATA, SEG_SEL, frame_tick
  );

  modport slave (
    input  digit_bcd, dp_mask, blink_mask, load_req,
    output load_ack, SEG_DATA, SEG_SEL, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with blank gap, frame-aligned loads and blinking.
// Latency: outputs registered, valid for the whole BLANK/SHOW state; loads take effect at digit 0 of the next frame.
// Backpressure: load_req is a level sampled only at frame boundaries, acknowledged by a one-cycle load_ack.
// Optional feature macro: LEADING_ZERO_SUPPRESS_EN (blank leading zero digits, digit 0 always shown).
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 5,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 250
) (
  input  logic           CLK,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BLK_W   = $clog2(BLINK_FRAMES + 1);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLINK_TOP  = BLK_W'(BLINK_FRAMES);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Registered state
  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [BLK_W-1:0]        r_blink_cnt;
  logic                    r_blink_phase;
  logic [4*NUM_DIGITS-1:0] r_bcd_sh;
  logic [NUM_DIGITS-1:0]   r_dp_sh;
  logic [NUM_DIGITS-1:0]   r_blink_sh;
  logic [7:0]              r_seg_data;
  logic [NUM_DIGITS-1:0]   r_seg_sel;
  logic                    r_frame_tick;
  logic                    r_load_ack;

  // Next-state values
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [BLK_W-1:0]        w_blink_cnt_nxt;
  logic [BLK_W-1:0]        w_blink_inc;
  logic                    w_blink_phase_nxt;
  logic [4*NUM_DIGITS-1:0] w_bcd_nxt;
  logic [NUM_DIGITS-1:0]   w_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_blink_nxt;
  logic [7:0]              w_seg_data_nxt;
  logic [NUM_DIGITS-1:0]   w_seg_sel_nxt;
  logic                    w_frame_tick_nxt;
  logic                    w_load_ack_nxt;
  logic                    w_boundary;
  logic [3:0]              w_digit;

`ifdef LEADING_ZERO_SUPPRESS_EN
  logic [NUM_DIGITS-1:0]   w_sup;
`endif

  // BCD to {g,f,e,d,c,b,a}; non-decimal codes show a dash
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign w_blink_inc = r_blink_cnt + 1'b1;

  // Scan sequencing, frame boundary detection, blink timing and shadow capture
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_idx_nxt         = r_idx;
    w_blink_cnt_nxt   = r_blink_cnt;
    w_blink_phase_nxt = r_blink_phase;
    w_bcd_nxt         = r_bcd_sh;
    w_dp_nxt          = r_dp_sh;
    w_blink_nxt       = r_blink_sh;
    w_frame_tick_nxt  = 1'b0;
    w_load_ack_nxt    = 1'b0;
    w_boundary        = 1'b0;

    case (r_state)
      ST_BLANK: begin
        // With no blank gap configured this state is only seen once, right after reset
        if ((BLANK_CYCLES == 0) || (r_cnt == BLANK_LAST)) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt  = '0;
            w_boundary = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_boundary) begin
      w_frame_tick_nxt = 1'b1;
      if (w_blink_inc == BLINK_TOP) begin
        w_blink_cnt_nxt   = '0;
        w_blink_phase_nxt = ~r_blink_phase;
      end else begin
        w_blink_cnt_nxt = w_blink_inc;
      end
      // Capture only here so a frame never mixes old and new digits
      if (bus.load_req) begin
        w_bcd_nxt      = bus.digit_bcd;
        w_dp_nxt       = bus.dp_mask;
        w_blink_nxt    = bus.blink_mask;
        w_load_ack_nxt = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_SUPPRESS_EN
  // A digit is suppressed when it and every more-significant digit is a bare zero
  always_comb begin
    logic run;
    w_sup = '0;
    run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run      = run && (w_bcd_nxt[4*i +: 4] == 4'd0) && !w_dp_nxt[i];
      w_sup[i] = run;
    end
  end
`endif

  // Pin values for the upcoming state, built from the upcoming shadow/blink values
  always_comb begin
    w_seg_sel_nxt  = '1;
    w_seg_data_nxt = 8'h00;
    w_digit        = w_bcd_nxt[4*w_idx_nxt +: 4];
    if (w_state_nxt == ST_SHOW) begin
      w_seg_sel_nxt  = ~(NUM_DIGITS'(1) << w_idx_nxt);
      w_seg_data_nxt = {w_dp_nxt[w_idx_nxt], seg7(w_digit)};
      if (w_blink_phase_nxt && w_blink_nxt[w_idx_nxt]) begin
        w_seg_data_nxt = 8'h00;
      end
`ifdef LEADING_ZERO_SUPPRESS_EN
      if (w_sup[w_idx_nxt]) begin
        w_seg_data_nxt = 8'h00;
      end
`endif
    end
  end

  // State and output registers; reset drops everything to a blank display at once
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_BLANK;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_bcd_sh      <= '0;
      r_dp_sh       <= '0;
      r_blink_sh    <= '0;
      r_seg_data    <= 8'h00;
      r_seg_sel     <= '1;
      r_frame_tick  <= 1'b0;
      r_load_ack    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
      r_bcd_sh      <= w_bcd_nxt;
      r_dp_sh       <= w_dp_nxt;
      r_blink_sh    <= w_blink_nxt;
      r_seg_data    <= w_seg_data_nxt;
      r_seg_sel     <= w_seg_sel_nxt;
      r_frame_tick  <= w_frame_tick_nxt;
      r_load_ack    <= w_load_ack_nxt;
    end
  end

  assign bus.SEG_DATA   = r_seg_data;
  assign bus.SEG_SEL    = r_seg_sel;
  assign bus.frame_tick = r_frame_tick;
  assign bus.load_ack   = r_load_ack;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: expected digit images are queued per frame and popped per SHOW slot.
// Uses 5 digits, 4-cycle SHOW, 1-cycle BLANK, 2-frame blink half-period (25-cycle frames).
// Honours LEADING_ZERO_SUPPRESS_EN when building expected digit images.
module tb_seg_scan_ctrl;

  localparam int ND           = 5;
  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int BLINK_FRAMES = 2;

  typedef struct packed {
    logic [4:0] sel;
    logic [7:0] data;
  } exp_t;

  logic CLK;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb[$];
  logic [6:0] seg_tab [16];

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the five expected digit images (digit 0 first) for frame number fn since reset
  task automatic push_frame(input logic [19:0] bcd, input logic [4:0] dp, input logic [4:0] blk, input int fn);
    exp_t e;
    logic phase;
    logic [3:0] d;
`ifdef LEADING_ZERO_SUPPRESS_EN
    logic run;
    logic [4:0] sup;
    sup = '0;
    run = 1'b1;
    for (int i = ND - 1; i >= 1; i--) begin
      run    = run && (bcd[4*i +: 4] == 4'd0) && !dp[i];
      sup[i] = run;
    end
`endif
    phase = ((fn / BLINK_FRAMES) % 2) == 1;
    for (int i = 0; i < ND; i++) begin
      d      = bcd[4*i +: 4];
      e.sel  = ~(5'b00001 << i);
      e.data = {dp[i], seg_tab[d]};
      if (phase && blk[i]) e.data = 8'h00;
`ifdef LEADING_ZERO_SUPPRESS_EN
      if (sup[i]) e.data = 8'h00;
`endif
      sb.push_back(e);
    end
  endtask

  // Follow n SHOW slots, popping and comparing one expected image per slot
  task automatic wait_digits(input int n);
    exp_t e;
    int guard;
    int len;
    logic [4:0] sel0;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      while (bus.SEG_SEL === 5'h1F && guard < 40) begin
        tick();
        guard++;
      end
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
      else e = '0;
      check($sformatf("sel_k%0d", k), 32'(bus.SEG_SEL), 32'(e.sel));
      check($sformatf("data_sel%02h", e.sel), 32'(bus.SEG_DATA), 32'(e.data));
      sel0 = bus.SEG_SEL;
      len  = 0;
      while (bus.SEG_SEL === sel0 && len < 40) begin
        tick();
        len++;
      end
      check("show_len", 32'(len), 32'(SCAN_DIV));
      check("gap_sel", 32'(bus.SEG_SEL), 32'h1F);
      check("gap_data", 32'(bus.SEG_DATA), 32'h00);
    end
  endtask

  task automatic check_boundary(input string tag, input logic ack_exp);
    check({tag, "_tick"}, 32'(bus.frame_tick), 32'd1);
    check({tag, "_ack"}, 32'(bus.load_ack), 32'(ack_exp));
  endtask

  initial begin
    logic [4:0] lsel [26];
    logic [7:0] ldata[26];
    logic       ltick[26];
    logic       lack [26];
    int ft;
    int guard;
    int cur;

    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    rst            = 1'b0;
    bus.digit_bcd  = '0;
    bus.dp_mask    = '0;
    bus.blink_mask = '0;
    bus.load_req   = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_sel", 32'(bus.SEG_SEL), 32'h1F);
    check("rst_data", 32'(bus.SEG_DATA), 32'h00);
    check("rst_ack", 32'(bus.load_ack), 32'd0);
    check("rst_tick", 32'(bus.frame_tick), 32'd0);

    // First frame timing after release
    rst = 1'b1;
    lsel[0] = bus.SEG_SEL; ldata[0] = bus.SEG_DATA; ltick[0] = bus.frame_tick; lack[0] = bus.load_ack;
    for (int k = 1; k < 26; k++) begin
      tick();
      lsel[k] = bus.SEG_SEL; ldata[k] = bus.SEG_DATA; ltick[k] = bus.frame_tick; lack[k] = bus.load_ack;
    end
    check("c0_blank", 32'(lsel[0]), 32'h1F);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("c%0d_sel", k), 32'(lsel[k]), 32'h1E);
      check($sformatf("c%0d_data", k), 32'(ldata[k]), 32'h3F);
    end
    check("c5_blank", 32'(lsel[5]), 32'h1F);
    ft = -1;
    for (int k = 0; k < 26; k++) if (ltick[k] && ft < 0) ft = k;
    check("first_tick_cycle", 32'(ft), 32'd25);
    check("first_tick_noack", 32'(lack[25]), 32'd0);

    // Load 12345 requested mid-frame: frame 1 keeps old data, ack lands with tick
    cur = 1;
    bus.digit_bcd = 20'h12345;
    bus.load_req  = 1'b1;
    push_frame(20'h00000, 5'b0, 5'b0, cur);
    wait_digits(5);
    check_boundary("ld1", 1'b1);
    bus.load_req = 1'b0;
    cur++;
    push_frame(20'h12345, 5'b0, 5'b0, cur);
    wait_digits(5);
    check_boundary("idle1", 1'b0);
    cur++;

    // Dash plus decimal point on digit 2, held request gives a second load
    bus.digit_bcd = 20'h98B76;
    bus.dp_mask   = 5'b00100;
    bus.load_req  = 1'b1;
    push_frame(20'h12345, 5'b0, 5'b0, cur);
    wait_digits(5);
    check_boundary("ld2", 1'b1);
    cur++;
    push_frame(20'h98B76, 5'b00100, 5'b0, cur);
    wait_digits(5);
    check_boundary("ld2_again", 1'b1);
    cur++;

    // Blink digit 0
    bus.digit_bcd  = 20'h12345;
    bus.dp_mask    = 5'b0;
    bus.blink_mask = 5'b00001;
    push_frame(20'h98B76, 5'b00100, 5'b0, cur);
    wait_digits(5);
    check_boundary("ld3", 1'b1);
    bus.load_req = 1'b0;
    cur++;
    for (int f = 0; f < 4; f++) begin
      push_frame(20'h12345, 5'b0, 5'b00001, cur);
      wait_digits(5);
      check_boundary($sformatf("blink_f%0d", cur), 1'b0);
      cur++;
    end

    // Request raised and dropped between boundaries is lost
    push_frame(20'h12345, 5'b0, 5'b00001, cur);
    wait_digits(2);
    bus.digit_bcd = 20'h77777;
    bus.load_req  = 1'b1;
    wait_digits(1);
    bus.load_req = 1'b0;
    wait_digits(2);
    check_boundary("lost", 1'b0);
    cur++;
    push_frame(20'h12345, 5'b0, 5'b00001, cur);
    wait_digits(5);
    check_boundary("lost_after", 1'b0);
    cur++;

    // Asynchronous reset in the middle of digit 3, with a request pending
    push_frame(20'h12345, 5'b0, 5'b00001, cur);
    wait_digits(3);
    guard = 0;
    while (bus.SEG_SEL !== 5'b10111 && guard < 20) begin
      tick();
      guard++;
    end
    check("pre_rst_d3", 32'(bus.SEG_SEL), 32'h17);
    tick();
    tick();
    bus.digit_bcd = 20'h55555;
    bus.load_req  = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    #1;
    check("async_sel", 32'(bus.SEG_SEL), 32'h1F);
    check("async_data", 32'(bus.SEG_DATA), 32'h00);
    check("async_tick", 32'(bus.frame_tick), 32'd0);
    check("async_ack", 32'(bus.load_ack), 32'd0);
    sb.delete();
    repeat (2) tick();
    rst = 1'b1;
    bus.load_req = 1'b0;
    cur = 0;
    push_frame(20'h00000, 5'b0, 5'b0, cur);
    wait_digits(5);
    check_boundary("post_rst", 1'b0);
    cur++;

    // Leading-zero patterns
    bus.digit_bcd  = 20'h00105;
    bus.dp_mask    = 5'b0;
    bus.blink_mask = 5'b0;
    bus.load_req   = 1'b1;
    push_frame(20'h00000, 5'b0, 5'b0, cur);
    wait_digits(5);
    check_boundary("lz1", 1'b1);
    bus.digit_bcd = 20'h00000;
    cur++;
    push_frame(20'h00105, 5'b0, 5'b0, cur);
    wait_digits(5);
    check_boundary("lz2", 1'b1);
    bus.load_req = 1'b0;
    cur++;
    push_frame(20'h00000, 5'b0, 5'b0, cur);
    wait_digits(5);
    check_boundary("lz_end", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 5-digit 7-segment display driven by the digital clock top level. It owns the SEG_DATA/SEG_SEL pins and sequences one digit at a time with an anti-ghosting blank gap. Digit data is captured from the timekeeping logic through a frame-aligned load handshake. It also provides per-digit blinking for time-set mode.

Parameters:
NUM_DIGITS, 5, number of digits scanned (digit 0 = rightmost, SEG_SEL bit 0)
SCAN_DIV, 1000, CLK cycles a digit is driven per slot (>=1)
BLANK_CYCLES, 2, CLK cycles all digits are off before each digit (>=0; 0 = no blank state)
BLINK_FRAMES, 250, full scan frames per blink half-period (>=1)

Ports:
CLK  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
digit_bcd  in  4*NUM_DIGITS  BCD digit i at [4i+3:4i]
dp_mask  in  NUM_DIGITS  decimal-point enable per digit
blink_mask  in  NUM_DIGITS  digit blinks when bit set
load_req  in  1  level request to capture digit_bcd/dp_mask/blink_mask
load_ack  out  1  one-cycle pulse: inputs captured
SEG_DATA  out  8  {dp,g,f,e,d,c,b,a}, active-high
SEG_SEL  out  NUM_DIGITS  digit select, active-low
frame_tick  out  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (rst=0, asynchronous, also mid-frame): state=BLANK, digit index=0, counters=0, blink_phase=0, shadow regs=0; SEG_SEL=all 1s, SEG_DATA=8'h00, load_ack=0, frame_tick=0.
- FSM: BLANK -> SHOW -> BLANK. BLANK lasts BLANK_CYCLES cycles (skipped if 0), SHOW lasts SCAN_DIV cycles. At SHOW end, index increments and wraps NUM_DIGITS-1 -> 0. Slot = BLANK_CYCLES+SCAN_DIV cycles. Frame = NUM_DIGITS slots.
- All outputs are registered and updated on the same edge as the state change, so they are valid for the whole state.
- BLANK: SEG_SEL all 1s, SEG_DATA=0.
- SHOW digit i: SEG_SEL=~(1<<i); SEG_DATA={dp_shadow[i], decode(bcd_shadow[i])}.
- Decode: 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F. Values 10..15 = 40 (dash).
- Blink: if blink_phase=1 and blink_shadow[i]=1, SEG_DATA=0 during SHOW; SEG_SEL still asserted.
- Frame boundary: the edge ending SHOW of digit NUM_DIGITS-1.
  - frame_tick is high for the following cycle (first cycle of digit 0's slot). In the first frame after reset, frame_tick does not fire at cycle 0.
  - The blink frame counter increments at each boundary. When it reaches BLINK_FRAMES it clears and blink_phase toggles.
- Load handshake:
  - load_req is sampled only at frame boundaries.
  - If load_req=1, all three shadow regs capture the inputs, and load_ack=1 in the same cycle as frame_tick.
  - The requester holds inputs stable and load_req high until ack, then drops load_req. If load_req is still high at the next boundary, a second load occurs (legal).
  - Captured data takes effect from digit 0 of the new frame, so no frame ever mixes old and new digits.
  - Requests raised and dropped between boundaries are lost.
- Reset asserted mid-handshake: the load is lost; load_ack stays 0.

Optional Feature:
LEADING_ZERO_SUPPRESS_EN: when defined, a digit displays blank (SEG_DATA=0, select still driven) if its BCD is 0, its dp bit is 0, and every more-significant digit is also suppressed. Digit 0 is never suppressed. Evaluation uses the shadow regs. When undefined, all digits display normally; the bench sees 3F for zeros.

Test Plan:
- Params 5/4/1/2, rst low then high, all shadow=0 -> SEG_SEL 11111 for 1 cycle, then 11110 for 4 cycles with SEG_DATA=3F; slot period 5; first frame_tick at cycle 25.
- Hold load_req=1 with digit_bcd=20'h12345 mid-frame -> no change until boundary. At the boundary, load_ack and frame_tick pulse together. Digit 0 then shows 6D, digit 4 shows 06.
- digit_bcd digit 2=4'hB, dp_mask=5'b00100, loaded -> during digit 2 SHOW, SEG_DATA=C0.
- blink_mask=5'b00001, BLINK_FRAMES=2 -> digit 0 SEG_DATA=0 during frames 2-3 and visible in frames 0-1 and 4-5; SEG_SEL=11110 throughout.
- Drop rst to 0 mid-SHOW of digit 3 -> outputs go to reset values immediately without a clock edge. After release, scan restarts at digit 0 and shadow regs read 0.
- LEADING_ZERO_SUPPRESS_EN defined, load 20'h00105 -> digits 4 and 3 show 00, digit 2 shows 06, digit 1 shows 3F. Load 20'h00000 -> only digit 0 shows 3F.
